// File: rtl/dffram_pkg.sv
// Shared state encoding and helpers for the dual-port DFF RAM.
package dffram_pkg;

    typedef logic [0:0] clr_state_t;

    localparam clr_state_t ST_IDLE  = 1'b0;
    localparam clr_state_t ST_CLEAR = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       en
    );
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/dffram_clr_fsm.sv
// Clear sequencer: walks the array after reset or on request, owns busy.
module dffram_clr_fsm
    import dffram_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_BW = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    output logic               busy_o,
    output logic               clr_we_o,
    output logic [ADDR_BW-1:0] clr_addr_o
);

    clr_state_t         state_q, state_d;
    logic [ADDR_BW-1:0] addr_q, addr_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    addr_d  = '0;
                end
            end
            ST_CLEAR: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == ADDR_BW'(DEPTH - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign busy_o     = (state_q == ST_CLEAR);
    assign clr_we_o   = busy_o;
    assign clr_addr_o = addr_q;

endmodule

// File: rtl/dffram_2p_clr.sv
// 1W/1R DFF RAM with byte enables, bypass and a clear sequencer.
// DFFRAM_OUT_REG_EN adds an output register stage (read latency 2).
module dffram_2p_clr
    import dffram_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 256,
    parameter int               BYPASS    = 1,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0,
    localparam int              ADDR_BW   = clog2(DEPTH),
    localparam int              NBYTES    = WIDTH / 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    output logic               busy_o,
    input  logic               wr_en_i,
    input  logic [ADDR_BW-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]   wr_data_i,
    input  logic [NBYTES-1:0]  wr_be_i,
    input  logic               rd_en_i,
    input  logic [ADDR_BW-1:0] rd_addr_i,
    output logic [WIDTH-1:0]   rd_data_o,
    output logic               rd_valid_o
);

    logic               busy, clr_we;
    logic [ADDR_BW-1:0] clr_addr;
    logic               wr_in, rd_in, wr_ok, rd_ok, hit;
    logic [WIDTH-1:0]   wr_old, wr_word, rd_old, rd_word;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   rdata_q;
    logic               rvalid_q;

    dffram_clr_fsm #(
        .DEPTH   (DEPTH),
        .ADDR_BW (ADDR_BW)
    ) u_clr_fsm (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr_i),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign wr_in = 32'(wr_addr_i) < DEPTH;
    assign rd_in = 32'(rd_addr_i) < DEPTH;
    assign wr_ok = wr_en_i & ~busy & ~rst_i & wr_in;
    assign rd_ok = rd_en_i & ~busy & ~rst_i;
    assign hit   = wr_ok & (wr_addr_i == rd_addr_i);

    // Out-of-range reads yield zero; hit implies rd_in, so bypass stays in range
    always_comb begin
        wr_old  = wr_in ? mem_q[wr_addr_i] : '0;
        rd_old  = rd_in ? mem_q[rd_addr_i] : '0;
        wr_word = wr_old;
        rd_word = rd_old;
        for (int b = 0; b < NBYTES; b++) begin
            wr_word[8*b +: 8] = byte_merge(wr_old[8*b +: 8],
                                           wr_data_i[8*b +: 8], wr_be_i[b]);
            rd_word[8*b +: 8] = byte_merge(rd_old[8*b +: 8],
                                           wr_data_i[8*b +: 8],
                                           (BYPASS != 0) && hit && wr_be_i[b]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_we)     mem_q[clr_addr]  <= CLR_VALUE;
        else if (wr_ok) mem_q[wr_addr_i] <= wr_word;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_ok;
            if (rd_ok) rdata_q <= rd_word;
        end
    end

`ifdef DFFRAM_OUT_REG_EN
    logic [WIDTH-1:0] odata_q;
    logic             ovalid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            odata_q  <= '0;
            ovalid_q <= 1'b0;
        end else begin
            ovalid_q <= rvalid_q;
            if (rvalid_q) odata_q <= rdata_q;
        end
    end

    assign rd_data_o  = odata_q;
    assign rd_valid_o = ovalid_q;
`else
    assign rd_data_o  = rdata_q;
    assign rd_valid_o = rvalid_q;
`endif

    assign busy_o = busy;

endmodule
